// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - two-client burst scheduler for the DDR3 MCB user port (option: DDR_ARB_FIXED_PRIO_EN)
module ddr_port_arbiter #(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c0_req,
  input  logic          c0_we,
  input  logic [29:0]   c0_addr,
  input  logic [6:0]    c0_len,
  output logic          c0_gnt,
  input  logic [DW-1:0] c0_wdata,
  output logic          c0_wack,
  output logic [DW-1:0] c0_rdata,
  output logic          c0_rvalid,
  output logic          c0_done,
  output logic          c0_err,
  input  logic          c1_req,
  input  logic          c1_we,
  input  logic [29:0]   c1_addr,
  input  logic [6:0]    c1_len,
  output logic          c1_gnt,
  input  logic [DW-1:0] c1_wdata,
  output logic          c1_wack,
  output logic [DW-1:0] c1_rdata,
  output logic          c1_rvalid,
  output logic          c1_done,
  output logic          c1_err,
  output logic [6:0]    u_wr_len,
  output logic [6:0]    u_rd_len,
  output logic [29:0]   u_wr_addr,
  output logic [29:0]   u_rd_addr,
  output logic [DW-1:0] u_wr_data,
  output logic          u_wr_en,
  output logic          u_rd_en,
  output logic          u_wr_cmd_en,
  output logic          u_rd_cmd_en,
  input  logic [DW-1:0] u_rd_data,
  input  logic          u_wr_rdy,
  input  logic          u_rd_rdy,
  input  logic          u_wr_cmd_done,
  input  logic          u_rd_cmd_done
);

  // Byte address is aligned down to one DW-bit word.
  localparam logic [29:0] ADDR_MASK = ~(30'(DW / 8) - 30'd1);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_CMD, WR_WAIT, RD_CMD, RD_DATA, DONE
  } state_t;

  state_t      state;
  logic        idx;      // granted client
  logic        reject;   // current request had an illegal length
  logic [29:0] addr_q;
  logic [6:0]  len_q;
  logic [6:0]  beat;
  logic [6:0]  beat_nxt;
  logic        win;
  logic        sel_we;
  logic [29:0] sel_addr;
  logic [6:0]  sel_len;
  logic        sel_bad;
  logic        unused_rd_cmd_done;

`ifdef DDR_ARB_FIXED_PRIO_EN
  assign win = ~c0_req;
`else
  logic last;
  assign win = (c0_req & c1_req) ? ~last : ~c0_req;
`endif

  assign sel_we   = win ? c1_we   : c0_we;
  assign sel_addr = win ? c1_addr : c0_addr;
  assign sel_len  = win ? c1_len  : c0_len;
  assign sel_bad  = (sel_len == 7'd0) || (sel_len > 7'd64);
  assign beat_nxt = beat + 7'd1;

  // Read completion is tracked by counting drained beats, not by the wrapper's done.
  assign unused_rd_cmd_done = u_rd_cmd_done;

  // Transaction sequencer: arbitration, request latch and beat counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= 1'b0;
      reject <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      beat   <= '0;
`ifndef DDR_ARB_FIXED_PRIO_EN
      last   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (c0_req | c1_req) begin
            idx    <= win;
`ifndef DDR_ARB_FIXED_PRIO_EN
            last   <= win;
`endif
            addr_q <= sel_addr & ADDR_MASK;
            len_q  <= sel_len;
            beat   <= '0;
            reject <= sel_bad;
            if (sel_bad)     state <= DONE;
            else if (sel_we) state <= WR_DATA;
            else             state <= RD_CMD;
          end
        end
        WR_DATA: begin
          if (u_wr_rdy) begin
            beat <= beat_nxt;
            if (beat_nxt == len_q) state <= WR_CMD;
          end
        end
        WR_CMD:  state <= WR_WAIT;
        WR_WAIT: if (u_wr_cmd_done) state <= DONE;
        RD_CMD:  state <= RD_DATA;
        RD_DATA: begin
          if (u_rd_rdy) begin
            beat <= beat_nxt;
            if (beat_nxt == len_q) state <= DONE;
          end
        end
        DONE: begin
          reject <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign c0_gnt    = (state != IDLE) && !idx;
  assign c1_gnt    = (state != IDLE) &&  idx;
  assign c0_wack   = (state == WR_DATA) && u_wr_rdy && !idx;
  assign c1_wack   = (state == WR_DATA) && u_wr_rdy &&  idx;
  assign c0_rvalid = (state == RD_DATA) && u_rd_rdy && !idx;
  assign c1_rvalid = (state == RD_DATA) && u_rd_rdy &&  idx;
  assign c0_done   = (state == DONE) && !idx;
  assign c1_done   = (state == DONE) &&  idx;
  assign c0_err    = c0_done && reject;
  assign c1_err    = c1_done && reject;
  assign c0_rdata  = u_rd_data;
  assign c1_rdata  = u_rd_data;

  assign u_wr_data   = idx ? c1_wdata : c0_wdata;
  assign u_wr_addr   = addr_q;
  assign u_rd_addr   = addr_q;
  assign u_wr_len    = len_q;
  assign u_rd_len    = len_q;
  assign u_wr_en     = (state == WR_DATA);
  assign u_rd_en     = (state == RD_DATA);
  assign u_wr_cmd_en = (state == WR_CMD);
  assign u_rd_cmd_en = (state == RD_CMD);

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - randomized self-checking bench for ddr_port_arbiter
module tb_ddr_port_arbiter;
  localparam int DW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          c0_req, c0_we, c0_gnt, c0_wack, c0_rvalid, c0_done, c0_err;
  logic          c1_req, c1_we, c1_gnt, c1_wack, c1_rvalid, c1_done, c1_err;
  logic [29:0]   c0_addr, c1_addr, u_wr_addr, u_rd_addr;
  logic [6:0]    c0_len, c1_len, u_wr_len, u_rd_len;
  logic [DW-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata, u_wr_data, u_rd_data;
  logic          u_wr_en, u_rd_en, u_wr_cmd_en, u_rd_cmd_en;
  logic          u_wr_rdy, u_rd_rdy, u_wr_cmd_done, u_rd_cmd_done;

  ddr_port_arbiter #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_len(c0_len), .c0_gnt(c0_gnt),
    .c0_wdata(c0_wdata), .c0_wack(c0_wack), .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid),
    .c0_done(c0_done), .c0_err(c0_err),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_len(c1_len), .c1_gnt(c1_gnt),
    .c1_wdata(c1_wdata), .c1_wack(c1_wack), .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
    .c1_done(c1_done), .c1_err(c1_err),
    .u_wr_len(u_wr_len), .u_rd_len(u_rd_len), .u_wr_addr(u_wr_addr), .u_rd_addr(u_rd_addr),
    .u_wr_data(u_wr_data), .u_wr_en(u_wr_en), .u_rd_en(u_rd_en),
    .u_wr_cmd_en(u_wr_cmd_en), .u_rd_cmd_en(u_rd_cmd_en),
    .u_rd_data(u_rd_data), .u_wr_rdy(u_wr_rdy), .u_rd_rdy(u_rd_rdy),
    .u_wr_cmd_done(u_wr_cmd_done), .u_rd_cmd_done(u_rd_cmd_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // client request descriptors
  bit            r_req[2], r_we[2], renew[2];
  logic [29:0]   r_addr[2];
  logic [6:0]    r_len[2];
  bit            drv_req[2], last_req[2];
  int            rise_cyc[2];
  logic [DW-1:0] cw[2];

  // reference model state
  int m_last;
  int last_done_cyc = -100;
  int wcd_sched = -1;
  int cd_cyc = -100;
  int stall_left = 0;
  bit chk_drop = 0;
  int idle_bad = 0;

  // current transaction bookkeeping
  int          cur = -1;
  bit          t_we, t_ok;
  logic [29:0] t_addr;
  logic [6:0]  t_len;
  int          gnt_cyc, beats_w, beats_r, wren_cnt, exp_wren, rden_cnt, exp_rden;
  int          wcmd_cnt, rcmd_cnt, rcmd_cyc, wcmd_cyc, lastw_cyc, lastrv_cyc, bad, data_bad;
  bit          wr_phase, rd_phase, rd_pend;
  logic [29:0] cmd_addr;
  logic [6:0]  cmd_len;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Arbitration rule from the request levels seen while idle.
  function automatic int predict(input bit a, input bit b);
    if (a && b) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (m_last == 1) ? 0 : 1;
`endif
    end
    return a ? 0 : 1;
  endfunction

  task automatic new_params(input int c);
    r_we[c]   = 1'($urandom % 2);
    r_addr[c] = 30'($urandom);
    if ($urandom % 6 == 0) r_len[c] = ($urandom % 2 == 1) ? 7'd0 : 7'(65 + $urandom % 63);
    else                   r_len[c] = 7'($urandom_range(1, 64));
  endtask

  task automatic serve(input int n_done, input int mode, input int abort_rv);
    int got = 0;
    int budget = 3000;
    int c, o, lref;
    bit r;
    bit o_gnt[2], o_wack[2], o_rv[2], o_done[2], o_err[2];
    logic [DW-1:0] o_rd[2];
    while (got < n_done) begin
      if (budget == 0) begin
        check("timeout", got, n_done);
        return;
      end
      budget--;
      @(negedge clk);
      cyc++;
      last_req = drv_req;
      for (int i = 0; i < 2; i++) begin
        drv_req[i] = r_req[i];
        if (drv_req[i] && !last_req[i]) rise_cyc[i] = cyc;
      end
      c0_req = drv_req[0]; c0_we = r_we[0]; c0_addr = r_addr[0]; c0_len = r_len[0]; c0_wdata = cw[0];
      c1_req = drv_req[1]; c1_we = r_we[1]; c1_addr = r_addr[1]; c1_len = r_len[1]; c1_wdata = cw[1];
      case (mode)
        0: r = 1'b1;
        1: r = 1'(cyc % 2);
        2: r = ($urandom % 4 != 0);
        default: begin
          r = 1'b1;
          if (beats_w + beats_r == 32 && stall_left > 0) begin
            r = 1'b0;
            stall_left--;
          end
        end
      endcase
      u_wr_rdy = r;
      u_rd_rdy = r;
      u_rd_data = rand_word();
      u_wr_cmd_done = 1'b0;
      if (wcd_sched == 0) begin
        u_wr_cmd_done = 1'b1;
        cd_cyc = cyc;
        wcd_sched = -1;
      end else if (wcd_sched > 0) wcd_sched--;
      u_rd_cmd_done = 1'($urandom % 2);
      #1;
      o_gnt[0] = c0_gnt;  o_wack[0] = c0_wack; o_rv[0] = c0_rvalid; o_done[0] = c0_done; o_err[0] = c0_err; o_rd[0] = c0_rdata;
      o_gnt[1] = c1_gnt;  o_wack[1] = c1_wack; o_rv[1] = c1_rvalid; o_done[1] = c1_done; o_err[1] = c1_err; o_rd[1] = c1_rdata;
      if (chk_drop) begin
        check("gnt_drop", int'({o_gnt[0], o_gnt[1]}), 0);
        chk_drop = 0;
      end
      if (cur < 0) begin
        if (o_gnt[0] || o_gnt[1]) begin
          c = o_gnt[1] ? 1 : 0;
          check("arb_winner", c, predict(last_req[0], last_req[1]));
          lref = (rise_cyc[c] > last_done_cyc + 1) ? rise_cyc[c] : last_done_cyc + 1;
          check("gnt_latency", cyc - lref, 1);
          m_last = c; cur = c;
          t_we = r_we[c]; t_addr = r_addr[c]; t_len = r_len[c];
          t_ok = (t_len >= 1) && (t_len <= 64);
          gnt_cyc = cyc; beats_w = 0; beats_r = 0; wren_cnt = 0; exp_wren = 0; rden_cnt = 0; exp_rden = 0;
          wcmd_cnt = 0; rcmd_cnt = 0; rcmd_cyc = -100; wcmd_cyc = -100; lastw_cyc = -100; lastrv_cyc = -100;
          bad = 0; data_bad = 0; cd_cyc = -100;
          wr_phase = t_ok && t_we; rd_phase = 0; rd_pend = 0;
        end else if (u_wr_en || u_rd_en || u_wr_cmd_en || u_rd_cmd_en || o_wack[0] || o_wack[1] ||
                     o_rv[0] || o_rv[1] || o_done[0] || o_done[1] || o_err[0] || o_err[1]) begin
          idle_bad++;
        end
      end
      if (cur >= 0) begin
        o = 1 - cur;
        if (rd_pend) begin rd_phase = 1; rd_pend = 0; end
        if (o_gnt[o] || o_wack[o] || o_rv[o] || o_done[o] || o_err[o]) bad++;
        if (!o_gnt[cur]) bad++;
        if (u_wr_cmd_en && u_rd_cmd_en) bad++;
        if (o_rd[o] !== u_rd_data) data_bad++;
        // write side
        if (o_wack[cur] != (wr_phase && u_wr_rdy)) bad++;
        if (wr_phase) exp_wren++;
        if (u_wr_en) wren_cnt++;
        if (o_wack[cur]) begin
          if (u_wr_data !== cw[cur]) data_bad++;
          beats_w++;
          cw[cur] = rand_word();
          if (beats_w == int'(t_len)) begin wr_phase = 0; lastw_cyc = cyc; end
        end
        if (u_wr_cmd_en) begin
          wcmd_cnt++; wcmd_cyc = cyc; cmd_addr = u_wr_addr; cmd_len = u_wr_len;
          wcd_sched = $urandom_range(0, 3);
        end
        // read side
        if (o_rv[cur] != (rd_phase && u_rd_rdy)) bad++;
        if (rd_phase) exp_rden++;
        if (u_rd_en) rden_cnt++;
        if (o_rv[cur]) begin
          if (o_rd[cur] !== u_rd_data) data_bad++;
          beats_r++;
          if (beats_r == int'(t_len)) begin rd_phase = 0; lastrv_cyc = cyc; end
        end
        if (u_rd_cmd_en) begin
          rcmd_cnt++; rcmd_cyc = cyc; cmd_addr = u_rd_addr; cmd_len = u_rd_len; rd_pend = 1;
        end
        if (o_done[cur]) begin
          if (!t_ok) begin
            check("rej_err", int'(o_err[cur]), 1);
            check("rej_done_cyc", cyc, gnt_cyc);
            check("rej_activity", wren_cnt + rden_cnt + wcmd_cnt + rcmd_cnt, 0);
          end else if (t_we) begin
            check("wr_err", int'(o_err[cur]), 0);
            check("wr_beats", beats_w, int'(t_len));
            check("wr_en_cycles", wren_cnt, exp_wren);
            check("wr_cmd_count", wcmd_cnt, 1);
            check("wr_cmd_cyc", wcmd_cyc, lastw_cyc + 1);
            check("wr_cmd_addr", int'(cmd_addr), int'(t_addr & ~30'hF));
            check("wr_cmd_len", int'(cmd_len), int'(t_len));
            check("wr_done_lat", cyc - cd_cyc, 1);
            check("wr_rd_side", rden_cnt + rcmd_cnt, 0);
          end else begin
            check("rd_err", int'(o_err[cur]), 0);
            check("rd_beats", beats_r, int'(t_len));
            check("rd_en_cycles", rden_cnt, exp_rden);
            check("rd_cmd_count", rcmd_cnt, 1);
            check("rd_cmd_cyc", rcmd_cyc, gnt_cyc);
            check("rd_cmd_addr", int'(cmd_addr), int'(t_addr & ~30'hF));
            check("rd_cmd_len", int'(cmd_len), int'(t_len));
            check("rd_done_lat", cyc - lastrv_cyc, 1);
            check("rd_wr_side", wren_cnt + wcmd_cnt, 0);
          end
          check("protocol", bad, 0);
          check("data", data_bad, 0);
          last_done_cyc = cyc;
          chk_drop = 1;
          got++;
          if (renew[cur]) new_params(cur);
          else r_req[cur] = 0;
          cur = -1;
        end else if (abort_rv > 0 && beats_r == abort_rv) begin
          return;
        end
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_len = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_len = '0;
    u_wr_rdy = 0; u_rd_rdy = 0; u_wr_cmd_done = 0; u_rd_cmd_done = 0;
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 0; r_we[i] = 0; renew[i] = 0; r_addr[i] = '0; r_len[i] = '0;
      drv_req[i] = 0; last_req[i] = 0; rise_cyc[i] = -100; cw[i] = rand_word();
    end
    c0_wdata = cw[0]; c1_wdata = cw[1];
    u_rd_data = rand_word();
    m_last = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_client_out", int'({c0_gnt, c0_wack, c0_rvalid, c0_done, c0_err,
                                  c1_gnt, c1_wack, c1_rvalid, c1_done, c1_err}), 0);
    check("rst_u_en", int'({u_wr_en, u_rd_en, u_wr_cmd_en, u_rd_cmd_en}), 0);
    check("rst_u_addr_len", int'(u_wr_addr) + int'(u_rd_addr) + int'(u_wr_len) + int'(u_rd_len), 0);
    check("rst_wr_data", int'(u_wr_data === c0_wdata), 1);
    check("rst_rdata", int'(c1_rdata === u_rd_data && c0_rdata === u_rd_data), 1);
    rst_n = 1'b1;

    // c0 write 0x100 len 4, FIFO always ready
    r_req[0] = 1; r_we[0] = 1; r_addr[0] = 30'h100; r_len[0] = 7'd4;
    serve(1, 0, 0);
    // c1 read 0x2000 len 8, FIFO toggling
    r_req[1] = 1; r_we[1] = 0; r_addr[1] = 30'h2000; r_len[1] = 7'd8;
    serve(1, 1, 0);
    // illegal lengths on both clients
    r_req[0] = 1; r_we[0] = 1; r_addr[0] = 30'h40;  r_len[0] = 7'd0;
    r_req[1] = 1; r_we[1] = 0; r_addr[1] = 30'h80;  r_len[1] = 7'd65;
    serve(2, 0, 0);
    // 64-beat write with a 10-cycle FIFO-full stall mid-burst
    stall_left = 10;
    r_req[1] = 1; r_we[1] = 1; r_addr[1] = 30'h12345; r_len[1] = 7'd64;
    serve(1, 3, 0);
    // both clients requesting continuously
    new_params(0); new_params(1);
    r_req[0] = 1; r_req[1] = 1; renew[0] = 1; renew[1] = 1;
    serve(8, 2, 0);
    renew[0] = 0; renew[1] = 0;
    serve(int'(r_req[0]) + int'(r_req[1]), 2, 0);
    // randomized single and paired requests
    for (int k = 0; k < 16; k++) begin
      int c;
      c = $urandom % 2;
      new_params(c); r_req[c] = 1;
      n = 1;
      if ($urandom % 3 == 0) begin new_params(1 - c); r_req[1 - c] = 1; n = 2; end
      serve(n, $urandom_range(0, 2), 0);
    end
    // reset during read beat 3 of 8
    r_req[1] = 1; r_we[1] = 0; r_addr[1] = 30'h3000; r_len[1] = 7'd8;
    serve(1, 0, 3);
    @(negedge clk);
    cyc++;
    rst_n = 1'b0;
    r_req[1] = 0; drv_req[1] = 0; c1_req = 0;
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    #1;
    check("rst_mid_gnt", int'({c0_gnt, c1_gnt}), 0);
    check("rst_mid_done", int'({c0_done, c1_done, c0_err, c1_err}), 0);
    check("rst_mid_rd_en", int'({u_rd_en, u_rd_cmd_en}), 0);
    cur = -1; m_last = 1; rd_phase = 0; rd_pend = 0; wcd_sched = -1; last_done_cyc = cyc;
    r_req[0] = 1; r_we[0] = 0; r_addr[0] = 30'h3047; r_len[0] = 7'd5;
    serve(1, 2, 0);
    check("idle_activity", idle_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
